// File: rtl/instr_decode.sv
// RV32I instruction decoder: immediate generation, ALU/regfile/branch controls,
// and a sticky flag that remembers any illegal instruction since reset.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [2:0]  imm_type,
    output logic [31:0] imm,
    output logic        alu_imm,
    output logic [2:0]  alu_op,
    output logic        alu_alt,
    output logic        reg_wen,
    output logic [1:0]  pc_imm,
    output logic        op_illegal,
    output logic        illegal_seen
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    logic       dec_alu_imm;
    logic [2:0] dec_alu_op;
    logic       dec_alu_alt;
    logic       dec_reg_wen;
    logic [1:0] dec_pc_imm;

    logic illegal_seen_d;
    logic illegal_seen_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        imm_type = IMM_NONE;
        imm      = 32'd0;
        case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                imm      = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                imm      = {instr[31:12], 12'd0};
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                imm      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Branches compare via the ALU; pc_imm[1] is the zero-flag value that takes the branch.
    always_comb begin
        dec_alu_imm = 1'b0;
        dec_alu_op  = 3'b000;
        dec_alu_alt = 1'b0;
        dec_reg_wen = 1'b0;
        dec_pc_imm  = 2'b00;
        op_illegal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_alu_op  = funct3;
                dec_reg_wen = 1'b1;
                if (funct7 == F7_BASE) begin
                    op_illegal = 1'b0;
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    op_illegal  = 1'b0;
                    dec_alu_alt = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_alu_imm = 1'b1;
                dec_alu_op  = funct3;
                dec_reg_wen = 1'b1;
                case (funct3)
                    3'b001:  op_illegal = (funct7 != F7_BASE);
                    3'b101: begin
                        op_illegal  = !(funct7 == F7_BASE || funct7 == F7_ALT);
                        dec_alu_alt = (funct7 == F7_ALT);
                    end
                    default: op_illegal = (funct7 == F7_ALT);
                endcase
            end
            OPC_BRANCH: begin
                op_illegal = 1'b0;
                case (funct3)
                    3'b000: begin dec_alu_op = 3'b000; dec_alu_alt = 1'b1; dec_pc_imm = 2'b11; end
                    3'b001: begin dec_alu_op = 3'b000; dec_alu_alt = 1'b1; dec_pc_imm = 2'b01; end
                    3'b100: begin dec_alu_op = 3'b010; dec_pc_imm = 2'b01; end
                    3'b101: begin dec_alu_op = 3'b010; dec_pc_imm = 2'b11; end
                    3'b110: begin dec_alu_op = 3'b011; dec_pc_imm = 2'b01; end
                    3'b111: begin dec_alu_op = 3'b011; dec_pc_imm = 2'b11; end
                    default: op_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Side-effecting controls are quenched for illegal instructions and during reset.
    always_comb begin
        alu_imm = dec_alu_imm;
        alu_op  = dec_alu_op;
        alu_alt = dec_alu_alt;
        reg_wen = dec_reg_wen;
        pc_imm  = dec_pc_imm;
        if (op_illegal || reset) begin
            alu_imm = 1'b0;
            alu_op  = 3'b000;
            alu_alt = 1'b0;
            reg_wen = 1'b0;
            pc_imm  = 2'b00;
        end
    end

    always_comb begin
        illegal_seen_d = reset ? 1'b0 : (illegal_seen_q | op_illegal);
    end

    always_ff @(posedge clk) begin
        illegal_seen_q <= illegal_seen_d;
    end

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: a reference decoder pushes expected
// outputs to a scoreboard queue, popped and compared once the outputs settle.
module tb_instr_decode;

    typedef struct packed {
        logic [2:0]  imm_type;
        logic [31:0] imm;
        logic        alu_imm;
        logic [2:0]  alu_op;
        logic        alu_alt;
        logic        reg_wen;
        logic [1:0]  pc_imm;
        logic        op_illegal;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic        alu_imm;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic        reg_wen;
    logic [1:0]  pc_imm;
    logic        op_illegal;
    logic        illegal_seen;

    exp_t exp_q[$];
    int   total_cnt;
    int   bad_cnt;
    logic seen_model;

    instr_decode dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .imm_type     (imm_type),
        .imm          (imm),
        .alu_imm      (alu_imm),
        .alu_op       (alu_op),
        .alu_alt      (alu_alt),
        .reg_wen      (reg_wen),
        .pc_imm       (pc_imm),
        .op_illegal   (op_illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder written as a flat if-chain rather than the RTL's case structure.
    function automatic exp_t refDecode(input logic [31:0] i, input logic rst);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.op_illegal = 1'b1;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
            e.imm_type = 3'd1;
            e.imm = {{20{i[31]}}, i[31:20]};
        end else if (op == 7'h23) begin
            e.imm_type = 3'd2;
            e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        end else if (op == 7'h63) begin
            e.imm_type = 3'd3;
            e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        end else if (op == 7'h37 || op == 7'h17) begin
            e.imm_type = 3'd4;
            e.imm = {i[31:12], 12'd0};
        end else if (op == 7'h6F) begin
            e.imm_type = 3'd5;
            e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        end
        if (op == 7'h33) begin
            if (f7 == 7'h00) e.op_illegal = 1'b0;
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                e.op_illegal = 1'b0;
                e.alu_alt = 1'b1;
            end
            e.alu_op = f3;
            e.reg_wen = 1'b1;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1) e.op_illegal = (f7 != 7'h00);
            else if (f3 == 3'd5) e.op_illegal = (f7 != 7'h00 && f7 != 7'h20);
            else e.op_illegal = (f7 == 7'h20);
            e.alu_alt = (f3 == 3'd5 && f7 == 7'h20);
            e.alu_imm = 1'b1;
            e.alu_op = f3;
            e.reg_wen = 1'b1;
        end else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            e.op_illegal = 1'b0;
            e.alu_op = (f3[2] == 1'b0) ? 3'd0 : (f3[1] ? 3'd3 : 3'd2);
            e.alu_alt = (f3[2] == 1'b0);
            e.pc_imm = {f3[0] ~^ f3[2], 1'b1};
        end
        if (e.op_illegal || rst) begin
            e.alu_imm = 1'b0;
            e.alu_op = 3'd0;
            e.alu_alt = 1'b0;
            e.reg_wen = 1'b0;
            e.pc_imm = 2'b00;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("[TB] FAIL %s instr=%h got=%h expected=%h", tag, instr, got, want);
        end
    endtask

    // Drive one instruction mid-cycle, check the combinational outputs, then the sticky flag after the edge.
    task automatic applyStimulus(input logic [31:0] i, input logic rst);
        exp_t e;
        @(negedge clk);
        instr = i;
        reset = rst;
        exp_q.push_back(refDecode(i, rst));
        #1;
        e = exp_q.pop_front();
        checkOutput("imm_type",   32'(imm_type),   32'(e.imm_type));
        checkOutput("imm",        imm,             e.imm);
        checkOutput("alu_imm",    32'(alu_imm),    32'(e.alu_imm));
        checkOutput("alu_op",     32'(alu_op),     32'(e.alu_op));
        checkOutput("alu_alt",    32'(alu_alt),    32'(e.alu_alt));
        checkOutput("reg_wen",    32'(reg_wen),    32'(e.reg_wen));
        checkOutput("pc_imm",     32'(pc_imm),     32'(e.pc_imm));
        checkOutput("op_illegal", 32'(op_illegal), 32'(e.op_illegal));
        @(posedge clk);
        seen_model = rst ? 1'b0 : (seen_model | e.op_illegal);
        #1;
        checkOutput("illegal_seen", 32'(illegal_seen), 32'(seen_model));
    endtask

    logic [6:0] opc_pool [9];

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        seen_model = 1'b0;
        reset      = 1'b1;
        instr      = 32'd0;
        opc_pool   = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};

        applyStimulus(32'h0000_0000, 1'b1);
        applyStimulus(32'h0050_0093, 1'b1);

        applyStimulus(32'h0050_0093, 1'b0);
        applyStimulus(32'h4020_81B3, 1'b0);
        applyStimulus(32'hFE20_8CE3, 1'b0);
        applyStimulus(32'hFE20_9CE3, 1'b0);
        applyStimulus(32'h4030_D093, 1'b0);
        applyStimulus(32'h0020_C463, 1'b0);
        applyStimulus(32'h0020_F463, 1'b0);
        applyStimulus(32'h0020_E463, 1'b0);
        applyStimulus(32'h0020_D463, 1'b0);
        applyStimulus(32'h0020_A1B3, 1'b0);
        applyStimulus(32'h4020_D1B3, 1'b0);
        applyStimulus(32'hFFF0_0093, 1'b0);
        applyStimulus(32'h0030_9093, 1'b0);
        checkOutput("seen_clean", 32'(illegal_seen), 32'd0);

        applyStimulus(32'h4030_A093, 1'b0);
        applyStimulus(32'h0050_0093, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);
        applyStimulus(32'h1234_50B7, 1'b0);
        applyStimulus(32'h4020_0093, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);

        applyStimulus(32'h4020_91B3, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);
        applyStimulus(32'h0200_9093, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);
        applyStimulus(32'h0020_A463, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);
        applyStimulus(32'hFE11_2E23, 1'b0);
        applyStimulus(32'h8000_00EF, 1'b0);
        applyStimulus(32'hFFFF_F117, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            r = $urandom;
            r[6:0] = opc_pool[$urandom_range(0, 8)];
            if (k % 4 == 0) r[31:25] = 7'h20;
            if (k % 4 == 1) r[31:25] = 7'h00;
            applyStimulus(r, (k % 9 == 8));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
# instr_decode

RV32I instruction decoder for the single-cycle core: classifies the fetched 32-bit instruction word, produces the sign-extended immediate, and drives the ALU, register-file write-enable and branch-control signals. It sits between instruction memory and the register file / ALU / PC-update logic. Decoding is combinational. A registered sticky flag records any illegal instruction seen since reset.

## Interface
- No parameters.
- clk  in  1  system clock (rising edge).
- reset  in  1  synchronous, active-high; clock clk.
- instr  in  32  instruction word from instruction memory.
- imm_type  out  3  immediate format: 0=none(R), 1=I, 2=S, 3=B, 4=U, 5=J.
- imm  out  32  immediate per imm_type; 0 when imm_type=0.
- alu_imm  out  1  ALU operand B selects imm (1) or rs2 (0).
- alu_op  out  3  ALU operation, funct3 encoding (000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and).
- alu_alt  out  1  alternate op: sub for 000, sra for 101.
- reg_wen  out  1  write rd with ALU result.
- pc_imm  out  2  bit0 = conditional branch; bit1 = ALU zero value on which the branch is taken.
- op_illegal  out  1  instruction not executable by this core.
- illegal_seen  out  1  registered sticky OR of op_illegal.

## Operation
- opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
- imm_type by opcode: 0010011/0000011/1100111→I; 0100011→S; 1100011→B; 0110111/0010111→U; 1101111→J; all else→0.
- imm: I=sext(instr[31:20]); S=sext({instr[31:25],instr[11:7]}); B=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U={instr[31:12],12'b0}; J=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- Executed subset: OP (0110011), OP-IMM (0010011), BRANCH (1100011). Every other opcode is illegal; its imm/imm_type are still produced.
- OP: alu_imm=0, alu_op=funct3, reg_wen=1, pc_imm=00. funct7=0000000 legal for all funct3; funct7=0100000 legal only for funct3 000/101 (alu_alt=1); otherwise illegal.
- OP-IMM: alu_imm=1, alu_op=funct3, reg_wen=1, pc_imm=00, alu_alt=0 except funct3=101 with funct7=0100000 (alu_alt=1). funct3=001 requires funct7=0000000; funct3=101 requires 0000000 or 0100000; otherwise illegal.
- BRANCH: alu_imm=0, reg_wen=0. BEQ: op 000 alt 1, pc_imm=11. BNE: op 000 alt 1, pc_imm=01. BLT: op 010 alt 0, pc_imm=01. BGE: op 010, pc_imm=11. BLTU: op 011, pc_imm=01. BGEU: op 011, pc_imm=11. funct3 010/011 illegal.
- Illegal (or reset high): reg_wen=0, pc_imm=00, alu_imm=0, alu_op=000, alu_alt=0; imm/imm_type unaffected. op_illegal itself is not masked by reset.
- rd=x0 is not suppressed here; the register file ignores x0 writes.

## Timing
- All outputs except illegal_seen combinational from instr/reset, zero latency.
- illegal_seen: on posedge clk, reset=1 → 0; else illegal_seen <= illegal_seen | op_illegal. Reset value 0; reset has priority over a simultaneous illegal instruction.
- While reset=1: reg_wen=0, pc_imm=00 (no register write or branch during reset cycle).

## Test plan
- instr=0x00500093 (addi x1,x0,5) → imm_type=1, imm=0x00000005, alu_imm=1, alu_op=000, alu_alt=0, reg_wen=1, pc_imm=00, op_illegal=0.
- instr=0x402081B3 (sub x3,x1,x2) → imm_type=0, imm=0, alu_imm=0, alu_op=000, alu_alt=1, reg_wen=1.
- instr=0xFE208CE3 (beq x1,x2,-8) → imm_type=3, imm=0xFFFFFFF8, alu_op=000, alu_alt=1, pc_imm=11, reg_wen=0; instr=0xFE209CE3 (bne) → pc_imm=01.
- instr=0x4030D093 (srai x1,x1,3) → alu_imm=1, alu_op=101, alu_alt=1, reg_wen=1; instr=0x4030A093 (funct7 0100000 on slti) → op_illegal=1, reg_wen=0.
- instr=0x123450B7 (lui) → imm_type=4, imm=0x12345000, op_illegal=1, reg_wen=0; next posedge illegal_seen=1; stays 1 with legal instrs until reset=1 edge → 0.
- reset=1 with instr=0x00500093 → reg_wen=0, pc_imm=00, imm=5; reset=1 with instr=0x00000000 at edge → illegal_seen=0.
